vga_timing_gen: RTL and testbench

//  Parametrised VGA/DVI timing generator with selectable test patterns.

---
 rtl/vga_timing_gen.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA/DVI raster timing generator with four built-in test
// patterns. A horizontal/vertical counter pair walks the raster; every
// output is decoded from the counters and registered, so all outputs
// describe the counter state of the previous cycle and stay aligned.
// Pixel coordinates and line/frame strobes are exported so downstream
// pixel sources can lock to the raster.
//
// Notes for integrators:
//  - The checker pattern uses hc[3]/vc[3], so H_TOTAL and V_TOTAL must
//    both be at least 16.
//  - H_BACK and V_BACK are expected to be non-zero so the sync pulse
//    ends inside the line/frame.
//  - Reset is asserted asynchronously. On release, one clock re-times the
//    release into run_q. The first output update follows on the next
//    clock, and frame_start is set there for the raster origin.
module vga_timing_gen #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1,
    parameter int BORDER    = 10,
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    output logic [2:0]    red,
    output logic [2:0]    green,
    output logic [1:0]    blue,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam int            HS_START = H_VISIBLE + H_FRONT;
    localparam int            HS_END   = HS_START + H_SYNC;
    localparam int            VS_START = V_VISIBLE + V_FRONT;
    localparam int            VS_END   = VS_START + V_SYNC;
    // Colour bars are H_VISIBLE/8 pixels wide. Any pixels left over at the
    // right edge stay in the last bar.
    localparam int            BAR_W    = ((H_VISIBLE / 8) > 0) ? (H_VISIBLE / 8) : 1;
    localparam logic [HW-1:0] BAR_LAST = HW'(BAR_W - 1);
    localparam logic          HS_ACT   = (HSYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic          VS_ACT   = (VSYNC_POL != 0) ? 1'b1 : 1'b0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          run_q;
    logic          run_d;
    logic [HW-1:0] hc_q;
    logic [HW-1:0] hc_d;
    logic [VW-1:0] vc_q;
    logic [VW-1:0] vc_d;
    logic [HW-1:0] bar_pix_q;
    logic [HW-1:0] bar_pix_d;
    logic [2:0]    bar_idx_q;
    logic [2:0]    bar_idx_d;
    logic [1:0]    mode_q;
    logic [1:0]    mode_d;

    // Registered outputs
    logic [2:0]    red_q;
    logic [2:0]    red_d;
    logic [2:0]    green_q;
    logic [2:0]    green_d;
    logic [1:0]    blue_q;
    logic [1:0]    blue_d;
    logic          hsync_q;
    logic          hsync_d;
    logic          vsync_q;
    logic          vsync_d;
    logic          blank_q;
    logic          blank_d;
    logic [HW-1:0] x_q;
    logic [HW-1:0] x_d;
    logic [VW-1:0] y_q;
    logic [VW-1:0] y_d;
    logic          line_start_q;
    logic          line_start_d;
    logic          frame_start_q;
    logic          frame_start_d;

    // ------------------------------------------------------------------
    // Decode signals
    // ------------------------------------------------------------------
    logic          frame_top_s;
    logic          line_top_s;
    logic [1:0]    mode_eff_s;
    logic          blank_s;
    logic          hsync_on_s;
    logic          vsync_on_s;
    logic          border_s;
    logic [2:0]    bar_col_s;
    logic [2:0]    pix_r_s;
    logic [2:0]    pix_g_s;
    logic [1:0]    pix_b_s;

    // Re-time the reset release: the raster starts one clock after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run_d;
        end
    end

    // run_d becomes 1 after reset and stays 1.
    always_comb begin
        run_d = 1'b1;
    end

    // Raster counters, bar tracker and frame-latched pattern select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q      <= '0;
            vc_q      <= '0;
            bar_pix_q <= '0;
            bar_idx_q <= 3'd0;
            mode_q    <= 2'd0;
        end else begin
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            mode_q    <= mode_d;
        end
    end

    // Advance hc/vc and the incremental bar position. Sample mode at the
    // raster origin only, so the pattern never changes mid-frame.
    always_comb begin
        hc_d      = hc_q;
        vc_d      = vc_q;
        bar_pix_d = bar_pix_q;
        bar_idx_d = bar_idx_q;
        mode_d    = mode_q;
        if (run_q) begin
            if (hc_q == H_LAST) begin
                hc_d      = '0;
                bar_pix_d = '0;
                bar_idx_d = 3'd0;
                if (vc_q == V_LAST) begin
                    vc_d = '0;
                end else begin
                    vc_d = vc_q + VW'(1);
                end
            end else begin
                hc_d = hc_q + HW'(1);
                if (bar_pix_q == BAR_LAST) begin
                    bar_pix_d = '0;
                    if (bar_idx_q == 3'd7) begin
                        bar_idx_d = 3'd7;
                    end else begin
                        bar_idx_d = bar_idx_q + 3'd1;
                    end
                end else begin
                    bar_pix_d = bar_pix_q + HW'(1);
                    bar_idx_d = bar_idx_q;
                end
            end
            if (frame_top_s) begin
                mode_d = mode;
            end else begin
                mode_d = mode_q;
            end
        end else begin
            hc_d = hc_q;
            vc_d = vc_q;
        end
    end

    // Decode sync, blanking and the pattern colour for the current hc/vc.
    always_comb begin
        line_top_s  = (hc_q == '0);
        frame_top_s = (hc_q == '0) && (vc_q == '0);
        // At the raster origin the incoming mode applies immediately, so
        // the first pixel of a frame already uses the new pattern.
        mode_eff_s  = frame_top_s ? mode : mode_q;
        blank_s     = (int'(hc_q) >= H_VISIBLE) || (int'(vc_q) >= V_VISIBLE);
        hsync_on_s  = (int'(hc_q) >= HS_START) && (int'(hc_q) < HS_END);
        vsync_on_s  = (int'(vc_q) >= VS_START) && (int'(vc_q) < VS_END);
        border_s    = (int'(hc_q) < BORDER) || (int'(hc_q) >= (H_VISIBLE - BORDER)) ||
                      (int'(vc_q) < BORDER) || (int'(vc_q) >= (V_VISIBLE - BORDER));
        // Bar 0 (left) is white and bar 7 (right) is black.
        bar_col_s   = ~bar_idx_q;
        pix_r_s     = 3'b000;
        pix_g_s     = 3'b000;
        pix_b_s     = 2'b00;
        if (blank_s) begin
            pix_r_s = 3'b000;
            pix_g_s = 3'b000;
            pix_b_s = 2'b00;
        end else begin
            case (mode_eff_s)
                2'd0: begin
                    if (border_s) begin
                        pix_b_s = 2'b11;
                    end else begin
                        pix_b_s = 2'b00;
                    end
                end
                2'd1: begin
                    pix_r_s = {3{bar_col_s[2]}};
                    pix_g_s = {3{bar_col_s[1]}};
                    pix_b_s = {2{bar_col_s[0]}};
                end
                2'd2: begin
                    if (hc_q[3] ^ vc_q[3]) begin
                        pix_r_s = 3'b111;
                        pix_g_s = 3'b111;
                        pix_b_s = 2'b11;
                    end else begin
                        pix_r_s = 3'b000;
                        pix_g_s = 3'b000;
                        pix_b_s = 2'b00;
                    end
                end
                2'd3: begin
                    pix_r_s = 3'b111;
                    pix_g_s = 3'b111;
                    pix_b_s = 2'b11;
                end
                default: begin
                    pix_r_s = 3'b000;
                    pix_g_s = 3'b000;
                    pix_b_s = 2'b00;
                end
            endcase
        end
    end

    // Next output values. The outputs hold idle levels until the raster runs.
    always_comb begin
        red_d         = 3'b000;
        green_d       = 3'b000;
        blue_d        = 2'b00;
        hsync_d       = ~HS_ACT;
        vsync_d       = ~VS_ACT;
        blank_d       = 1'b1;
        x_d           = '0;
        y_d           = '0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (run_q) begin
            red_d         = pix_r_s;
            green_d       = pix_g_s;
            blue_d        = pix_b_s;
            hsync_d       = hsync_on_s ? HS_ACT : ~HS_ACT;
            vsync_d       = vsync_on_s ? VS_ACT : ~VS_ACT;
            blank_d       = blank_s;
            x_d           = hc_q;
            y_d           = vc_q;
            line_start_d  = line_top_s;
            frame_start_d = frame_top_s;
        end else begin
            hsync_d = ~HS_ACT;
            vsync_d = ~VS_ACT;
            blank_d = 1'b1;
        end
    end

    // Output registers. Reset drives sync inactive, blanks the output and
    // clears colour, coordinates and strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q         <= 3'b000;
            green_q       <= 3'b000;
            blue_q        <= 2'b00;
            hsync_q       <= ~HS_ACT;
            vsync_q       <= ~VS_ACT;
            blank_q       <= 1'b1;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Uses a reduced raster so that several whole frames fit in a short run.
// A reference model computes every output from the cycle index with plain
// arithmetic (hc = t mod H_TOTAL, vc = (t div H_TOTAL) mod V_TOTAL).
// A table of hand-derived pixel colours is then checked against the
// colours captured during the run.
module tb_vga_timing_gen;

    localparam int HV = 64;
    localparam int HF = 4;
    localparam int HS = 8;
    localparam int HB = 6;
    localparam int VV = 24;
    localparam int VF = 2;
    localparam int VS = 3;
    localparam int VB = 3;
    localparam int BD = 3;
    localparam int HT = HV + HF + HS + HB;   // 82
    localparam int VT = VV + VF + VS + VB;   // 32
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [2:0]    r;
        logic [2:0]    g;
        logic [1:0]    b;
        logic          hs;
        logic          vs;
        logic          bl;
        logic [HW-1:0] x;
        logic [VW-1:0] y;
        logic          ls;
        logic          fs;
    } obs_t;

    typedef struct {
        int         m;
        int         x;
        int         y;
        logic [7:0] rgb;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'd0;

    logic [2:0]    red_a, green_a, red_b, green_b;
    logic [1:0]    blue_a, blue_b;
    logic          hsync_a, vsync_a, blank_a, ls_a, fs_a;
    logic          hsync_b, vsync_b, blank_b, ls_b, fs_b;
    logic [HW-1:0] x_a, x_b;
    logic [VW-1:0] y_a, y_b;
    obs_t          oa, ob;

    int n_vec = 0;
    int n_err = 0;
    int t_next = 0;
    int model_mode = 0;
    int cyc = 0;
    int last_ls = -1;
    int last_fs = -1;
    int line_y = 0;
    int hs_cnt = 0;
    int bl_cnt = 0;
    int vs_cnt = 0;
    logic prev_hs = 1'b0;

    logic [7:0] pix   [0:3][0:VT-1][0:HT-1];
    bit         pix_v [0:3][0:VT-1][0:HT-1];
    vec_t       tbl[$];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1), .VSYNC_POL(1), .BORDER(BD)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .red(red_a), .green(green_a), .blue(blue_a),
        .hsync(hsync_a), .vsync(vsync_a), .blank(blank_a),
        .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(0), .VSYNC_POL(0), .BORDER(BD)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .red(red_b), .green(green_b), .blue(blue_b),
        .hsync(hsync_b), .vsync(vsync_b), .blank(blank_b),
        .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
    );

    assign oa = {red_a, green_a, blue_a, hsync_a, vsync_a, blank_a, x_a, y_a, ls_a, fs_a};
    assign ob = {red_b, green_b, blue_b, hsync_b, vsync_b, blank_b, x_b, y_b, ls_b, fs_b};

    // Reference model: the expected outputs for raster cycle t under pattern m.
    function automatic obs_t model(int t, int m, logic hp, logic vp);
        obs_t o;
        int   hc, vc, bi, c;
        hc = t % HT;
        vc = (t / HT) % VT;
        o = '0;
        o.x  = HW'(hc);
        o.y  = VW'(vc);
        o.ls = (hc == 0);
        o.fs = (hc == 0) && (vc == 0);
        o.bl = (hc >= HV) || (vc >= VV);
        o.hs = (hc >= HV + HF && hc < HV + HF + HS) ? hp : ~hp;
        o.vs = (vc >= VV + VF && vc < VV + VF + VS) ? vp : ~vp;
        if (!o.bl) begin
            case (m)
                0: if (hc < BD || hc >= HV - BD || vc < BD || vc >= VV - BD) o.b = 2'b11;
                1: begin
                    bi = hc / (HV / 8);
                    if (bi > 7) bi = 7;
                    c = 7 - bi;
                    o.r = (c >= 4) ? 3'b111 : 3'b000;
                    o.g = (((c / 2) % 2) == 1) ? 3'b111 : 3'b000;
                    o.b = ((c % 2) == 1) ? 2'b11 : 2'b00;
                end
                2: if (((hc / 8) % 2) != ((vc / 8) % 2)) begin
                    o.r = 3'b111; o.g = 3'b111; o.b = 2'b11;
                end
                default: begin
                    o.r = 3'b111; o.g = 3'b111; o.b = 2'b11;
                end
            endcase
        end
        return o;
    endfunction

    function automatic obs_t idle_obs(logic hp, logic vp);
        obs_t o;
        o = '0;
        o.hs = ~hp;
        o.vs = ~vp;
        o.bl = 1'b1;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("x=%0d y=%0d r=%0d g=%0d b=%0d hs=%b vs=%b bl=%b ls=%b fs=%b",
                         o.x, o.y, o.r, o.g, o.b, o.hs, o.vs, o.bl, o.ls, o.fs);
    endfunction

    task automatic check_obs(input string nm, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got {%s} want {%s}", nm, t_next, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic reset_trackers();
        last_ls = -1; last_fs = -1; hs_cnt = 0; bl_cnt = 0; vs_cnt = 0;
        prev_hs = 1'b0; t_next = 0; model_mode = 0;
    endtask

    // One raster cycle: drive mode, clock, compare both DUTs against the model.
    task automatic step(input logic [1:0] m);
        obs_t ea, eb;
        int   hc, vc;
        mode = m;
        hc = t_next % HT;
        vc = (t_next / HT) % VT;
        if (hc == 0 && vc == 0) model_mode = int'(m);
        ea = model(t_next, model_mode, 1'b1, 1'b1);
        eb = model(t_next, model_mode, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_obs("raster", oa, ea);
        check_obs("raster_pol0", ob, eb);
        pix[model_mode][vc][hc]   = {oa.r, oa.g, oa.b};
        pix_v[model_mode][vc][hc] = 1'b1;
        if (oa.ls) begin
            if (last_ls >= 0) begin
                check_int("line_period", cyc - last_ls, HT);
                check_int("hsync_width", hs_cnt, HS);
                if (line_y < VV) check_int("blank_width", bl_cnt, HT - HV);
            end
            last_ls = cyc; line_y = int'(oa.y); hs_cnt = 0; bl_cnt = 0;
        end
        if (oa.fs) begin
            if (last_fs >= 0) begin
                check_int("frame_period", cyc - last_fs, FRAME);
                check_int("vsync_width", vs_cnt, VS * HT);
            end
            last_fs = cyc; vs_cnt = 0;
        end
        if (oa.hs && !prev_hs && last_ls >= 0) check_int("hsync_rise", cyc - last_ls, HV + HF);
        hs_cnt += int'(oa.hs);
        bl_cnt += int'(oa.bl);
        vs_cnt += int'(oa.vs);
        prev_hs = oa.hs;
        cyc++;
        t_next++;
        @(negedge clk);
    endtask

    // Release reset at a falling edge. The re-timing clock leaves the
    // outputs idle; the next clock shows the raster origin.
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_obs("sync_edge_a", oa, idle_obs(1'b1, 1'b1));
        check_obs("sync_edge_b", ob, idle_obs(1'b0, 1'b0));
        @(negedge clk);
        reset_trackers();
        step(2'd0);
        check_int("fs_2nd_edge", int'(oa.fs), 1);
    endtask

    initial begin
        logic [1:0] rm;
        int         guard;
        tbl.push_back('{0, 0, 0, 8'h03});   tbl.push_back('{0, 10, 10, 8'h00});
        tbl.push_back('{0, 63, 10, 8'h03}); tbl.push_back('{0, 10, 21, 8'h03});
        tbl.push_back('{0, 10, 20, 8'h00}); tbl.push_back('{0, 64, 5, 8'h00});
        tbl.push_back('{0, 2, 12, 8'h03});  tbl.push_back('{0, 3, 12, 8'h00});
        tbl.push_back('{0, 60, 12, 8'h00}); tbl.push_back('{0, 61, 12, 8'h03});
        tbl.push_back('{1, 0, 0, 8'hFF});   tbl.push_back('{1, 7, 0, 8'hFF});
        tbl.push_back('{1, 8, 0, 8'hFC});   tbl.push_back('{1, 20, 5, 8'hE3});
        tbl.push_back('{1, 56, 3, 8'h00});  tbl.push_back('{1, 63, 3, 8'h00});
        tbl.push_back('{1, 70, 0, 8'h00});
        tbl.push_back('{2, 8, 0, 8'hFF});   tbl.push_back('{2, 0, 0, 8'h00});
        tbl.push_back('{2, 8, 8, 8'h00});   tbl.push_back('{2, 0, 8, 8'hFF});
        tbl.push_back('{2, 15, 23, 8'hFF}); tbl.push_back('{2, 16, 16, 8'h00});
        tbl.push_back('{3, 5, 5, 8'hFF});   tbl.push_back('{3, 64, 5, 8'h00});
        tbl.push_back('{3, 5, 24, 8'h00});

        // Reset state: both polarities idle, blanked, zero colour and strobes.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_obs("reset_a", oa, idle_obs(1'b1, 1'b1));
        check_obs("reset_b", ob, idle_obs(1'b0, 1'b0));
        release_reset();

        // Rest of the first frame with border, then one full frame per pattern.
        for (int i = 1; i < FRAME; i++) step(2'd0);
        for (int m = 1; m < 4; m++) begin
            for (int i = 0; i < FRAME; i++) step(2'(m));
        end

        // Switch 0 -> 2 halfway through a frame: border stays until the next frame.
        for (int i = 0; i < FRAME; i++) begin
            step((i < 12 * HT) ? 2'd0 : 2'd2);
            if (i == 20 * HT) check_int("switch_keeps_border", int'({oa.r, oa.g, oa.b}), 8'h03);
        end
        for (int i = 0; i < FRAME; i++) begin
            step(2'd2);
            if (i == 8) check_int("switch_checker_next", int'({oa.r, oa.g, oa.b}), 8'hFF);
        end

        // Random pattern changes at arbitrary points across two frames.
        rm = 2'd1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ($urandom_range(0, 99) == 0) rm = 2'($urandom_range(0, 3));
            step(rm);
        end

        // Mid-frame reset while hsync and vsync are both active.
        guard = 0;
        step(2'd3);
        while (!(int'(oa.x) == HV + HF + 2 && int'(oa.y) == VV + VF + 1) && guard < FRAME + 4) begin
            step(2'd3);
            guard++;
        end
        check_int("reach_reset_point", guard < FRAME + 4 ? 1 : 0, 1);
        check_int("sync_before_reset", int'({oa.hs, oa.vs}), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_obs("async_reset_a", oa, idle_obs(1'b1, 1'b1));
        check_obs("async_reset_b", ob, idle_obs(1'b0, 1'b0));
        @(posedge clk);
        #1;
        check_obs("held_reset_a", oa, idle_obs(1'b1, 1'b1));
        release_reset();
        for (int i = 1; i < FRAME; i++) step(2'd1);

        // Hand-derived pixel table against the captured colours.
        foreach (tbl[i]) begin
            if (!pix_v[tbl[i].m][tbl[i].y][tbl[i].x]) begin
                n_vec++;
                n_err++;
                $display("FAIL pix_m%0d_x%0d_y%0d never observed", tbl[i].m, tbl[i].x, tbl[i].y);
            end else begin
                check_int($sformatf("pix_m%0d_x%0d_y%0d", tbl[i].m, tbl[i].x, tbl[i].y),
                          int'(pix[tbl[i].m][tbl[i].y][tbl[i].x]), int'(tbl[i].rgb));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
